// File: rtl/image_load_ctrl.sv
// Image-load and classify sequencer: streams one selected image from ROM into a flat
// pixel buffer, runs the processing element until done, and latches the class result.
module image_load_ctrl #(
    parameter int WIDTH   = 32,
    parameter int HEIGHT  = 32,
    parameter int CHANNEL = 3,
    parameter int PIX_W   = 8,
    parameter int ROM_LAT = 1,
    parameter int NUM_IMG = 4,
    parameter int ADDR_W  = 21,
    parameter int CLASS_W = 11,
    parameter int TIMEOUT = 1048576,
    localparam int unsigned N     = WIDTH * HEIGHT * CHANNEL,
    localparam int          SEL_W = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEL_W-1:0]     img_sel,
    output logic                 rom_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [PIX_W-1:0]     rom_data,
    output logic [N*PIX_W-1:0]   img,
    output logic                 pe_enable,
    input  logic                 pe_done,
    input  logic [CLASS_W-1:0]   pe_class,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CLASS_W-1:0]   class_out
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]         state;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [ROM_LAT-1:0] vpipe;
    logic [WD_W-1:0]    wdog;
    logic [SEL_W-1:0]   sel_c;

    always_comb begin
        sel_c = img_sel;
        if (img_sel > SEL_W'(NUM_IMG - 1))
            sel_c = SEL_W'(NUM_IMG - 1);
    end

    assign rom_en   = (state == S_LOAD);
    assign rom_addr = rom_en ? (base + ADDR_W'(rd_cnt)) : '0;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            base      <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            vpipe     <= '0;
            wdog      <= '0;
            pe_enable <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            class_out <= '0;
            img       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Valid pipe tracks ROM latency so each returned word lands at wr_cnt.
            vpipe[0] <= rom_en;
            for (int unsigned i = 1; i < ROM_LAT; i++)
                vpipe[i] <= vpipe[i-1];

            if (vpipe[ROM_LAT-1]) begin
                for (int unsigned i = 0; i < N; i++)
                    if (wr_cnt == CNT_W'(i))
                        img[i*PIX_W +: PIX_W] <= rom_data;
                wr_cnt <= wr_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base   <= ADDR_W'(sel_c) * ADDR_W'(N);
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == CNT_W'(N - 1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (wr_cnt == CNT_W'(N)) begin
                        pe_enable <= 1'b1;
                        wdog      <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // pe_done takes priority over a watchdog expiry in the same cycle.
                    if (pe_done) begin
                        class_out <= pe_class;
                        pe_enable <= 1'b0;
                        state     <= S_FIN;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        pe_enable <= 1'b0;
                        err       <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_load_ctrl.sv
// Self-checking bench for image_load_ctrl: small 2x2x1 image, ROM latency 2, watchdog 16,
// randomized jobs checked against a transaction-level model of address, image and result.
module tb_image_load_ctrl;

    localparam int WIDTH   = 2;
    localparam int HEIGHT  = 2;
    localparam int CHANNEL = 1;
    localparam int PIX_W   = 8;
    localparam int LAT     = 2;
    localparam int NUM_IMG = 5;
    localparam int ADDR_W  = 8;
    localparam int CLASS_W = 11;
    localparam int TMO     = 16;
    localparam int N       = WIDTH * HEIGHT * CHANNEL;
    localparam int SEL_W   = $clog2(NUM_IMG);

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [SEL_W-1:0]     img_sel = '0;
    logic                 rom_en;
    logic [ADDR_W-1:0]    rom_addr;
    logic [PIX_W-1:0]     rom_data;
    logic [N*PIX_W-1:0]   img;
    logic                 pe_enable;
    logic                 pe_done = 1'b0;
    logic [CLASS_W-1:0]   pe_class = '0;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [CLASS_W-1:0]   class_out;

    int checks = 0;
    int errors = 0;
    logic [CLASS_W-1:0] exp_class = '0;

    image_load_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CHANNEL(CHANNEL), .PIX_W(PIX_W),
        .ROM_LAT(LAT), .NUM_IMG(NUM_IMG), .ADDR_W(ADDR_W), .CLASS_W(CLASS_W),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .img_sel(img_sel),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .img(img),
        .pe_enable(pe_enable), .pe_done(pe_done), .pe_class(pe_class),
        .busy(busy), .done(done), .err(err), .class_out(class_out)
    );

    always #5 clk = ~clk;

    // ROM model: word a holds a+8'h10, data appears LAT clocks after the address is sampled.
    logic [PIX_W-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr + 8'h10;
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rom_en"}, 64'(rom_en), 64'd0);
        chk({tag, ".rom_addr"}, 64'(rom_addr), 64'd0);
        chk({tag, ".pe_enable"}, 64'(pe_enable), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done"}, 64'(done), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'd0);
        chk({tag, ".class_out"}, 64'(class_out), 64'd0);
        chk({tag, ".img"}, 64'(img), 64'd0);
    endtask

    task automatic reset_mid_load(input int sel, input int k);
        start = 1'b1; img_sel = SEL_W'(sel);
        tick;
        start = 1'b0;
        repeat (k) tick;
        reset = 1'b0;
        tick; chk_all_zero("rst1");
        tick; chk_all_zero("rst2");
        reset = 1'b1;
        exp_class = '0;
        repeat (LAT + 3) begin
            tick;
            chk("rst_img_quiet", 64'(img), 64'd0);
            chk("rst_idle", 64'(busy), 64'd0);
        end
    endtask

    // delay: RUN cycle index at which pe_done is raised; >= TMO means never.
    task automatic run_job(input int sel, input int delay, input logic [CLASS_W-1:0] cls);
        int s;
        int base;
        logic [N*PIX_W-1:0] exp_img;
        bit fin;
        s = (sel > NUM_IMG - 1) ? NUM_IMG - 1 : sel;
        base = s * N;
        for (int k = 0; k < N; k++) exp_img[k*PIX_W +: PIX_W] = 8'(base + k + 16);

        start = 1'b1; img_sel = SEL_W'(sel);
        tick;
        for (int k = 0; k < N; k++) begin
            chk("rom_en", 64'(rom_en), 64'd1);
            chk("rom_addr", 64'(rom_addr), 64'(base + k));
            start = 1'($urandom % 2); img_sel = SEL_W'($urandom);
            pe_done = 1'($urandom % 2); pe_class = CLASS_W'($urandom);
            tick;
        end
        chk("rom_en_off", 64'(rom_en), 64'd0);
        for (int c = N + 1; c <= N + LAT + 1; c++) begin
            pe_done = 1'($urandom % 2); pe_class = CLASS_W'($urandom);
            tick;
            chk("pe_en_timing", 64'(pe_enable), 64'(c == N + LAT + 1));
            chk("busy_load", 64'(busy), 64'd1);
        end
        chk("img", 64'(img), 64'(exp_img));

        fin = 1'b0;
        for (int t = 0; t < TMO && !fin; t++) begin
            chk("pe_en_run", 64'(pe_enable), 64'd1);
            chk("class_hold", 64'(class_out), 64'(exp_class));
            start = 1'($urandom % 2); img_sel = SEL_W'($urandom);
            pe_done = (t == delay);
            pe_class = (t == delay) ? cls : CLASS_W'($urandom);
            tick;
            start = 1'b0; pe_done = 1'b0;
            if (t == delay) begin
                fin = 1'b1;
                exp_class = cls;
                chk("class_out", 64'(class_out), 64'(exp_class));
                chk("pe_en_off", 64'(pe_enable), 64'd0);
                chk("done_early", 64'(done), 64'd0);
                chk("busy_fin", 64'(busy), 64'd1);
                tick;
                chk("done_pulse", 64'(done), 64'd1);
                chk("busy_after", 64'(busy), 64'd0);
                chk("err_ok", 64'(err), 64'd0);
                tick;
                chk("done_1cyc", 64'(done), 64'd0);
            end else if (t == TMO - 1) begin
                fin = 1'b1;
                chk("err_pulse", 64'(err), 64'd1);
                chk("pe_en_tmo", 64'(pe_enable), 64'd0);
                chk("busy_tmo", 64'(busy), 64'd0);
                chk("done_tmo", 64'(done), 64'd0);
                chk("class_keep", 64'(class_out), 64'(exp_class));
                tick;
                chk("err_1cyc", 64'(err), 64'd0);
            end else begin
                chk("err_quiet", 64'(err), 64'd0);
            end
        end
        chk("img_stable", 64'(img), 64'(exp_img));
    endtask

    initial begin
        tick; tick;
        chk_all_zero("por");
        reset = 1'b1;
        tick;

        reset_mid_load(1, 2);
        run_job(1, 3, 11'd7);
        run_job(1, 100, 11'd5);
        run_job(3, 0, 11'd300);
        run_job(5, 4, 11'd42);
        run_job(7, 15, 11'd1234);
        for (int j = 0; j < 12; j++)
            run_job(int'($urandom % 8), int'($urandom % 20), CLASS_W'($urandom));
        reset_mid_load(int'($urandom % 8), int'($urandom % N));
        run_job(int'($urandom % 8), int'($urandom % 10), CLASS_W'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
